dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 512-word data memory between two requesters: port 0 (the core's load/store path) and port 1 (the program loader / debug access path). It forwards at most one access per cycle to the memory. Port 0 has fixed priority, and an aging counter guarantees port 1 a slot after a bounded wait. The block tracks in-flight reads through a latency pipeline so that each read return is steered back to the port that issued it.

## Interface
- `DATA_W`, default 32: data width.
- `ADDR_W`, default 9: word address width.
- `RD_LAT`, default 1: memory read latency in cycles (>= 1).
- `MAX_WAIT`, default 4: cycles port 1 may be denied before it is forced to win (>= 1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  access request; held until granted.
- `we0`, `we1`  in  1  1 = write, 0 = read; valid with req.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `gnt0`, `gnt1`  out  1  access accepted this cycle (combinational).
- `rvalid0`, `rvalid1`  out  1  read data valid for that port.
- `rdata0`, `rdata1`  out  DATA_W  read data; equals `mem_rd_data` when rvalid, else 0.
- `mem_wr`, `mem_rd`  out  1  memory write / read strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wr_data`  out  DATA_W  memory write data.
- `mem_rd_data`  in  DATA_W  memory read data, valid RD_LAT cycles after `mem_rd`.
- `conflict_cnt`  out  16  saturating count of cycles in which both ports requested.

## Operation
- **Arbitration (combinational, per cycle)**
  - Only req0: grant 0.
  - Only req1: grant 1.
  - Both requesting: grant 1 if `wait_cnt == MAX_WAIT`, otherwise grant 0.
  - Neither requesting: no grant.
- **wait_cnt (register, 0..MAX_WAIT)**
  - Clears to 0 on any cycle gnt1 = 1.
  - Increments when req1 = 1 and gnt1 = 0.
  - Holds when req1 = 0.
  - Never exceeds MAX_WAIT.
- **Memory command**
  - Granted port's addr/wdata are driven onto the memory bus.
  - mem_wr = granted & we; mem_rd = granted & !we.
  - With no grant: mem_wr = mem_rd = 0, and mem_addr and mem_wr_data are 0.
- **Return pipeline**
  - RD_LAT-deep shift register of {valid, port}.
  - Stage 0 loads {mem_rd, granted port} each cycle.
  - When the last stage is valid, the matching rvalid is asserted.
  - Returns stay in issue order; back-to-back reads from either port are allowed every cycle.
- **conflict_cnt**: increments each cycle req0 & req1 are both 1, and saturates at 0xFFFF.
- A granted write completes in the grant cycle; no write acknowledge exists.

## Timing
- **Reset values**
  - wait_cnt, pipeline valids and conflict_cnt are 0.
  - gnt0/1, mem_wr and mem_rd are 0 while reset is asserted, regardless of req.
  - rvalid0/1 are 0 and rdata0/1 are 0.
- **Latency**
  - Grant has 0 cycles of latency from req.
  - A read granted in cycle N gives rvalid in cycle N+RD_LAT, for exactly 1 cycle.
- **Handshake**
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - It may drop req, or present a new request, in the cycle after gnt.
- **Worst-case port 1 wait**: port 1 is granted within MAX_WAIT+1 cycles of raising req1, even under continuous req0.
- **Simultaneous events**: a grant to port 1 in the same cycle the counter would increment clears the counter; clear wins.
- **Reset mid-operation**
  - In-flight reads are dropped, and no rvalid is produced for them after reset.
  - The memory sees no strobe during reset.
- **Reset deassertion**: arbitration resumes in the first clock after reset deasserts.

## Test plan
- **Single port 0 read**: reset, then req0 = 1, we0 = 0, addr0 = 0x010, with memory returning 0xDEADBEEF.
  - gnt0 = 1 in the same cycle, with mem_rd = 1 and mem_addr = 0x010.
  - rvalid0 = 1 and rdata0 = 0xDEADBEEF after RD_LAT = 1 cycle.
  - rvalid1 stays 0.
- **Port 1 write**: req1 = 1, we1 = 1, addr1 = 0x1FF, wdata1 = 0x12345678 with req0 = 0.
  - gnt1 = 1, mem_wr = 1, mem_addr = 0x1FF, mem_wr_data = 0x12345678.
- **Contention with aging**: req0 and req1 held high continuously with MAX_WAIT = 4.
  - gnt0 is granted in cycles 0-3 and gnt1 in cycle 4.
  - The pattern repeats 4:1 after that.
  - conflict_cnt increments once per cycle of contention.
- **Interleaved reads**: port 0 reads in cycle 0, port 1 reads in cycle 1, port 0 reads in cycle 2.
  - rvalid0, rvalid1, rvalid0 appear in cycles 1, 2 and 3.
  - Each carries the matching mem_rd_data.
- **Reset mid-read**: port 0 read granted, then reset asserted before return.
  - No rvalid0 is produced, and all counters read 0 after reset.
- **Saturation**: force contention for 65,540 cycles; conflict_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a fixed-priority port 0 and an aged port 1,
// steering each read return back to the port that issued it.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [15:0]       conflict_cnt
);
    localparam int WC_W = $clog2(MAX_WAIT + 1);

    logic [WC_W-1:0]   wait_q, wait_d;
    logic [RD_LAT-1:0] vld_q, vld_d, port_q, port_d;
    logic [15:0]       conf_q, conf_d;
    logic              any_gnt, sel_we;

    always_comb begin
        gnt1        = !reset && req1 && (!req0 || wait_q == WC_W'(MAX_WAIT));
        gnt0        = !reset && req0 && !gnt1;
        any_gnt     = gnt0 || gnt1;
        sel_we      = gnt1 ? we1 : we0;
        mem_wr      = any_gnt && sel_we;
        mem_rd      = any_gnt && !sel_we;
        mem_addr    = gnt1 ? addr1 : gnt0 ? addr0 : '0;
        mem_wr_data = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
        wait_d      = gnt1 ? '0 : (req1 && wait_q != WC_W'(MAX_WAIT)) ? wait_q + WC_W'(1) : wait_q;
        conf_d      = (req0 && req1 && conf_q != 16'hFFFF) ? conf_q + 16'd1 : conf_q;
        // Stage 0 enters at bit 0; the oldest read sits in the top bit.
        vld_d       = (vld_q << 1) | RD_LAT'(mem_rd);
        port_d      = (port_q << 1) | RD_LAT'(gnt1);
        rvalid0     = vld_q[RD_LAT-1] && !port_q[RD_LAT-1];
        rvalid1     = vld_q[RD_LAT-1] && port_q[RD_LAT-1];
        rdata0      = rvalid0 ? mem_rd_data : '0;
        rdata1      = rvalid1 ? mem_rd_data : '0;
        conflict_cnt = conf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            vld_q  <= '0;
            port_q <= '0;
            conf_q <= '0;
        end else begin
            wait_q <= wait_d;
            vld_q  <= vld_d;
            port_q <= port_d;
            conf_q <= conf_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a transaction-level model
// with its own memory image and a queue of expected read returns.
module tb_dmem_arbiter;
    localparam int DATA_W = 32, ADDR_W = 9, RD_LAT = 1, MAX_WAIT = 4;

    logic clk = 0, reset;
    logic req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1, mem_addr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_wr_data, mem_rd_data;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_wr, mem_rd;
    logic [15:0] conflict_cnt;

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] tb_mem [512];
    logic [DATA_W-1:0] model_mem [512];

    // One-cycle memory; idle cycles return noise so unqualified rdata is exposed.
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem_rd ? tb_mem[mem_addr] : $urandom;
    end

    typedef struct {int due; bit port; logic [DATA_W-1:0] data;} ret_t;
    ret_t rq[$];
    int checks = 0, errors = 0, cyc = 0, wait_m = 0, conf_m = 0;
    bit g0_last, g1_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        bit e0, e1, ev0, ev1, ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ew, ed;
        @(negedge clk);
        if (reset) begin
            rq.delete();
            wait_m = 0;
            conf_m = 0;
        end
        e1  = !reset && req1 && (!req0 || wait_m == MAX_WAIT);
        e0  = !reset && req0 && !e1;
        ea  = e1 ? addr1 : e0 ? addr0 : '0;
        ew  = e1 ? wdata1 : e0 ? wdata0 : '0;
        ewe = e1 ? we1 : we0;
        ev0 = 0; ev1 = 0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev0 = !rq[0].port;
            ev1 = rq[0].port;
            ed  = rq[0].data;
            void'(rq.pop_front());
        end
        chk("gnt", {gnt0, gnt1}, {e0, e1});
        chk("mem_strobe", {mem_wr, mem_rd}, {(e0 || e1) && ewe, (e0 || e1) && !ewe});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wr_data", mem_wr_data, ew);
        chk("rvalid", {rvalid0, rvalid1}, {ev0, ev1});
        chk("rdata0", rdata0, ev0 ? ed : '0);
        chk("rdata1", rdata1, ev1 ? ed : '0);
        chk("conflict_cnt", conflict_cnt, conf_m);
        if (!reset) begin
            if (req0 && req1 && conf_m < 65535) conf_m++;
            wait_m = e1 ? 0 : (req1 && wait_m < MAX_WAIT) ? wait_m + 1 : wait_m;
            if ((e0 || e1) && !ewe) rq.push_back(ret_t'{cyc + RD_LAT, e1, model_mem[ea]});
            if ((e0 || e1) && ewe) model_mem[ea] = ew;
        end
        g0_last = e0;
        g1_last = e1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rd0(input logic [ADDR_W-1:0] a);
        req0 = 1; we0 = 0; addr0 = a;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            model_mem[i] = $urandom;
            tb_mem[i] = model_mem[i];
        end
        reset = 1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) cycle();
        reset = 0;
        we0 = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("age_gnt1", gnt1, (i % 5) == 4);
            chk("age_conf", conflict_cnt, i);
            cycle();
        end
        req1 = 0;
        model_mem[9'h010] = 32'hDEADBEEF;
        tb_mem[9'h010] = 32'hDEADBEEF;
        rd0(9'h010);
        #2;
        chk("p0_gnt0", gnt0, 1);
        chk("p0_mem_rd", mem_rd, 1);
        chk("p0_addr", mem_addr, 9'h010);
        cycle();
        req0 = 0;
        #2;
        chk("p0_rvalid", {rvalid0, rvalid1}, 2'b10);
        chk("p0_rdata", rdata0, 32'hDEADBEEF);
        cycle();
        req1 = 1; we1 = 1; addr1 = 9'h1FF; wdata1 = 32'h12345678;
        #2;
        chk("p1_gnt1", gnt1, 1);
        chk("p1_wr", {mem_wr, mem_rd}, 2'b10);
        chk("p1_addr", mem_addr, 9'h1FF);
        chk("p1_wdata", mem_wr_data, 32'h12345678);
        cycle();
        req1 = 0;
        rd0(9'h020);
        cycle();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 9'h1FF;
        cycle();
        req1 = 0; rd0(9'h030);
        cycle();
        req0 = 0;
        repeat (2) cycle();
        for (int n = 0; n < 3000; n++) begin
            if (!req0 || g0_last) begin
                req0 = $urandom_range(0, 2) != 0; we0 = 1'($urandom);
                addr0 = 9'($urandom); wdata0 = $urandom;
            end
            if (!req1 || g1_last) begin
                req1 = 1'($urandom); we1 = 1'($urandom);
                addr1 = 9'($urandom); wdata1 = $urandom;
            end
            cycle();
        end
        req1 = 0;
        rd0(9'h040);
        cycle();
        req0 = 0;
        reset = 1;
        #2;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_conf", conflict_cnt, 0);
        req0 = 1; req1 = 1;
        cycle();
        reset = 0; req0 = 0; req1 = 0;
        repeat (2) cycle();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        repeat (65540) cycle();
        chk("sat", conflict_cnt, 16'hFFFF);
        req0 = 0; req1 = 0;
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
